// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: widths, mux-slot opcodes and the
// buffered result entry.
package alu_pkg;

    localparam int ALU_DW  = 16;
    localparam int ALU_OPW = 4;

    // One name per ALU result mux slot; the value is the select that picks it.
    typedef enum logic [ALU_OPW-1:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SHL  = 4'd6,  OP_SHR  = 4'd7,
        OP_SRA  = 4'd8,  OP_ROL  = 4'd9,  OP_ROR  = 4'd10, OP_INC  = 4'd11,
        OP_DEC  = 4'd12, OP_NEG  = 4'd13, OP_PASA = 4'd14, OP_PASB = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [ALU_DW-1:0]  data;
        logic [ALU_OPW-1:0] op;
        logic               zero;
        logic               neg;
        logic               par;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags for one result word: zero, sign and even parity.
module alu_flag_gen #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] data,
    output logic          zero,
    output logic          neg,
    output logic          par
);

    assign zero = ~|data;
    assign neg  = data[DW-1];
    assign par  = ^data;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU result mux: flags captured with the
// data, a two-entry skid buffer towards the consumer and a delivered-result count.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic [OPW-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [OPW-1:0] out_op,
    output logic           out_zero,
    output logic           out_neg,
    output logic           out_par,
    output logic [15:0]    out_count
);

    // Handshake: a beat moves on a rising edge where valid && ready are both 1;
    // valid never waits on ready, and in_ready is a flop (== skid empty), so no
    // combinational path runs from out_ready back to in_ready.

    alu_entry_t in_entry;
    alu_entry_t main_q;
    alu_entry_t skid_q;
    logic       main_v;
    logic       skid_v;
    logic       in_ready_q;
    logic [15:0] count_q;
    logic       in_fire;
    logic       out_fire;
    logic       f_zero;
    logic       f_neg;
    logic       f_par;

    alu_flag_gen #(.DW(DW)) u_flags (
        .data (in_data),
        .zero (f_zero),
        .neg  (f_neg),
        .par  (f_par)
    );

    always_comb begin
        in_entry      = '0;
        in_entry.data = in_data;
        in_entry.op   = in_op;
        in_entry.zero = f_zero;
        in_entry.neg  = f_neg;
        in_entry.par  = f_par;
    end

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = main_v && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            in_ready_q <= 1'b1;
            count_q    <= '0;
        end else begin
            if (out_fire) begin
                count_q <= count_q + 16'd1;
            end
            if (flush) begin
                // Data registers keep their last values; only occupancy is cleared.
                main_v     <= 1'b0;
                skid_v     <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (out_fire || !main_v) begin
                if (skid_v) begin
                    main_q     <= skid_q;
                    main_v     <= 1'b1;
                    skid_v     <= 1'b0;
                    in_ready_q <= 1'b1;
                end else if (in_fire) begin
                    main_q <= in_entry;
                    main_v <= 1'b1;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (in_fire) begin
                skid_q     <= in_entry;
                skid_v     <= 1'b1;
                in_ready_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign out_data  = main_q.data;
    assign out_op    = main_q.op;
    assign out_zero  = main_q.zero;
    assign out_neg   = main_q.neg;
    assign out_par   = main_q.par;
    assign out_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: randomized and directed beats checked
// against a plain-arithmetic model of the result and its flags.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W = ALU_DW + ALU_OPW + 3;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ALU_DW-1:0] in_data;
  logic [ALU_OPW-1:0] in_op;
  logic              out_valid;
  logic              out_ready;
  logic [ALU_DW-1:0] out_data;
  logic [ALU_OPW-1:0] out_op;
  logic              out_zero;
  logic              out_neg;
  logic              out_par;
  logic [15:0]       out_count;

  logic [W-1:0] exp_q[$];
  logic [15:0]  model_count;
  int checks;
  int failures;

  alu_result_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_par   (out_par),
    .out_count (out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [15:0] d, input logic [3:0] op);
    logic z, n, p;
    z = (d == 16'd0);
    n = (d >= 16'h8000);
    p = ($countones(d) % 2) == 1;
    return {d, op, z, n, p};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {out_data, out_op, out_zero, out_neg, out_par};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got 0x%0h expected none at %0t", got, $time);
      end else begin
        exp = exp_q.pop_front();
        check("entry", 32'(got), 32'(exp));
      end
      check("count_at_transfer", 32'(out_count), 32'(model_count));
      model_count = model_count + 16'd1;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; applies inputs for one cycle.
  task automatic cycle_in(input logic v, input logic [15:0] d, input logic [3:0] op, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    out_ready = rdy;
    @(negedge clk);
    if (v && in_ready && !flush) exp_q.push_back(model(d, op));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      cycle_in(1'b0, 16'h0, 4'h0, 1'b1);
      n++;
    end
    check("drain_done", 32'(exp_q.size() != 0 || out_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    int cyc;
    logic ready_dropped;
    logic [15:0] base;
    logic [15:0] k;
    logic v;

    checks = 0;
    failures = 0;
    model_count = 16'd0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_op = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_flags", 32'({out_op, out_zero, out_neg, out_par}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: zero result, op 3.
    cycle_in(1'b1, 16'h0000, 4'd3, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_word", 32'({out_data, out_op, out_zero, out_neg, out_par}), 32'({16'h0000, 4'd3, 3'b100}));
    cycle_in(1'b0, 16'h0, 4'h0, 1'b1);
    check("single_count", 32'(out_count), 32'd1);
    drain();

    // Back-to-back streaming, 20 beats.
    base = out_count;
    ready_dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) ready_dropped = 1'b1;
      cycle_in(1'b1, 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
    end
    drain();
    check("stream_in_ready_held", 32'(ready_dropped), 32'd0);
    check("stream_count", 32'(out_count), 32'(base + 16'd20));

    // Backpressure fills main and skid.
    cycle_in(1'b1, 16'h8001, 4'd1, 1'b0);
    cycle_in(1'b1, 16'h00FF, 4'd2, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_head_word", 32'({out_data, out_neg, out_par}), 32'({16'h8001, 2'b10}));
    cycle_in(1'b1, 16'h1234, 4'd9, 1'b0);
    check("bp_hold_word", 32'(out_data), 32'h8001);
    drain();
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Flush with both entries full and a beat offered.
    cycle_in(1'b1, 16'hAAAA, 4'd4, 1'b0);
    cycle_in(1'b1, 16'h5555, 4'd5, 1'b0);
    base = out_count;
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hC3C3;
    out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_count", 32'(out_count), 32'(base));
    for (int i = 0; i < 3; i++) cycle_in(1'b0, 16'h0, 4'h0, 1'b1);

    // Random valid/ready toggling, 1000 accepted beats.
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      v = 1'($urandom_range(0, 1));
      if (v && in_ready) sent++;
      cycle_in(v, 16'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      cyc++;
    end
    check("random_beats_sent", 32'(sent), 32'd1000);
    drain();
    check("random_count_model", 32'(out_count), 32'(model_count));

    // Wrap the counter to exactly zero.
    k = 16'd0 - model_count;
    for (int i = 0; i < int'(k); i++) begin
      cycle_in(1'b1, 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
    end
    drain();
    check("count_wrap", 32'(out_count), 32'd0);

    // Async reset mid-stream, between clock edges.
    for (int i = 0; i < 4; i++) cycle_in(1'b1, 16'hF00D + 16'(i), 4'd7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_word", 32'({out_data, out_op, out_zero, out_neg, out_par}), 32'd0);
    check("arst_count", 32'(out_count), 32'd0);
    exp_q.delete();
    model_count = 16'd0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle_in(1'b1, 16'h8000, 4'd15, 1'b0);
    check("post_rst_accept", 32'(out_valid), 32'd1);
    check("post_rst_word", 32'({out_data, out_zero, out_neg, out_par}), 32'({16'h8000, 3'b011}));
    drain();
    check("post_rst_count", 32'(out_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
